// File: rtl/ecc_pkg.sv
// Shared helpers for the SECDED check/correct pipeline: check-bit sizing,
// syndrome masks, codeword position mapping and correction flag encoding.
package ecc_pkg;

  localparam logic [1:0] FLG_CLEAN = 2'b00;
  localparam logic [1:0] FLG_CE    = 2'b01;
  localparam logic [1:0] FLG_UE    = 2'b10;

  function automatic int ham_w(input int data_w);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // Bit i contributes to syndrome bit k when bit k of (i+1) is set; parity MSB excluded.
  function automatic logic [127:0] ham_mask(input int k, input int cw);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) begin
      if (i < cw - 1 && (((i + 1) >> k) & 1) != 0) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic is_chk_pos(input int i);
    return ((i + 1) & i) == 0;
  endfunction

  function automatic int data_pos(input int d);
    int pos;
    int n;
    pos = 0;
    n   = 0;
    for (int i = 0; i < 128; i++) begin
      if (!is_chk_pos(i)) begin
        if (n == d) pos = i;
        n = n + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword.
module ecc_syndrome
  import ecc_pkg::*;
#(
  parameter int CW    = 39,
  parameter int HAM_W = 6
) (
  input  logic [CW-1:0]    code,
  output logic             p,
  output logic [HAM_W-1:0] s
);

  always_comb begin
    s = '0;
    for (int k = 0; k < HAM_W; k++) begin
      s[k] = ^(code & CW'(ham_mask(k, CW)));
    end
    p = ^code;
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED check-and-correct with valid/ready flow control,
// saturating CE/UE counters and a first-UE log.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16,
  localparam int HAM_W = ham_w(DATA_W),
  localparam int CW    = DATA_W + HAM_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_code,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_ce,
  output logic              out_ue,
  output logic [HAM_W:0]    out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  output logic              log_valid,
  output logic [TAG_W-1:0]  log_tag,
  output logic [HAM_W:0]    log_syn
);

  localparam logic [CW-1:0]    ONE     = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              syn_p;
  logic [HAM_W-1:0]  syn_s;
  logic              s1_adv, s2_adv, out_hs;

  logic              s1_valid_q, s1_valid_d;
  logic [CW-1:0]     s1_code_q, s1_code_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [HAM_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_ce_q, out_ce_d;
  logic              out_ue_q, out_ue_d;
  logic [HAM_W:0]    out_syn_q, out_syn_d;

  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;
  logic              log_valid_q, log_valid_d;
  logic [TAG_W-1:0]  log_tag_q, log_tag_d;
  logic [HAM_W:0]    log_syn_q, log_syn_d;

  logic [CW-1:0]     corr;
  logic [DATA_W-1:0] ext;
  logic [1:0]        flg;

  ecc_syndrome #(.CW(CW), .HAM_W(HAM_W)) u_syn (
    .code (in_code),
    .p    (syn_p),
    .s    (syn_s)
  );

  always_comb begin
    s2_adv = !out_valid_q | out_ready;
    s1_adv = !s1_valid_q | s2_adv;
    out_hs = out_valid_q & out_ready;
  end

  assign in_ready = s1_adv;

  // Syndrome s points at code bit s-1; anything past the parity-free range is uncorrectable.
  always_comb begin
    corr = s1_code_q;
    flg  = FLG_CLEAN;
    if (s1_syn_q == '0) begin
      if (s1_par_q) flg = FLG_CE;
    end else if (!s1_par_q) begin
      flg = FLG_UE;
    end else if (int'(s1_syn_q) < CW) begin
      corr = s1_code_q ^ (ONE << (s1_syn_q - HAM_W'(1)));
      flg  = FLG_CE;
    end else begin
      flg = FLG_UE;
    end
    ext = '0;
    for (int d = 0; d < DATA_W; d++) begin
      ext[d] = corr[data_pos(d)];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_tag_d   = s1_tag_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_tag_d  = in_tag;
        s1_syn_d  = syn_s;
        s1_par_d  = syn_p;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_ce_d    = out_ce_q;
    out_ue_d    = out_ue_q;
    out_syn_d   = out_syn_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = ext;
        out_tag_d  = s1_tag_q;
        out_ce_d   = (flg == FLG_CE);
        out_ue_d   = (flg == FLG_UE);
        out_syn_d  = {s1_par_q, s1_syn_q};
      end
    end
  end

  // A clear in the same cycle as an event handshake drops the event.
  always_comb begin
    ce_cnt_d    = ce_cnt_q;
    ue_cnt_d    = ue_cnt_q;
    log_valid_d = log_valid_q;
    log_tag_d   = log_tag_q;
    log_syn_d   = log_syn_q;
    if (clr_cnt) begin
      ce_cnt_d    = '0;
      ue_cnt_d    = '0;
      log_valid_d = 1'b0;
    end else if (out_hs) begin
      if (out_ce_q && ce_cnt_q != CNT_MAX) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (out_ue_q && ue_cnt_q != CNT_MAX) ue_cnt_d = ue_cnt_q + CNT_W'(1);
      if (out_ue_q && !log_valid_q) begin
        log_valid_d = 1'b1;
        log_tag_d   = out_tag_q;
        log_syn_d   = out_syn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_tag_q    <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_ce_q    <= 1'b0;
      out_ue_q    <= 1'b0;
      out_syn_q   <= '0;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
      log_valid_q <= 1'b0;
      log_tag_q   <= '0;
      log_syn_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_tag_q    <= s1_tag_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_ce_q    <= out_ce_d;
      out_ue_q    <= out_ue_d;
      out_syn_q   <= out_syn_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
      log_valid_q <= log_valid_d;
      log_tag_q   <= log_tag_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_ce    = out_ce_q;
  assign out_ue    = out_ue_q;
  assign out_syn   = out_syn_q;
  assign ce_cnt    = ce_cnt_q;
  assign ue_cnt    = ue_cnt_q;
  assign log_valid = log_valid_q;
  assign log_tag   = log_tag_q;
  assign log_syn   = log_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe: a default instance plus a CNT_W=2
// instance sharing the same traffic for counter saturation and clear.
module tb_ecc_secded_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [38:0] in_code = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;
  logic        clr_cnt = 1'b0;
  logic        clr_cnt2 = 1'b0;

  logic        in_ready, out_valid, out_ce, out_ue, log_valid;
  logic [31:0] out_data;
  logic [3:0]  out_tag, log_tag;
  logic [6:0]  out_syn, log_syn;
  logic [15:0] ce_cnt, ue_cnt;

  logic        b_in_ready, b_out_valid, b_out_ce, b_out_ue, b_log_valid;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_tag, b_log_tag;
  logic [6:0]  b_out_syn, b_log_syn;
  logic [1:0]  b_ce_cnt, b_ue_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ecc_secded_pipe #(.DATA_W(32), .TAG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_ce(out_ce), .out_ue(out_ue),
    .out_syn(out_syn), .clr_cnt(clr_cnt), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
    .log_valid(log_valid), .log_tag(log_tag), .log_syn(log_syn)
  );

  ecc_secded_pipe #(.DATA_W(32), .TAG_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .out_ce(b_out_ce), .out_ue(b_out_ue),
    .out_syn(b_out_syn), .clr_cnt(clr_cnt2), .ce_cnt(b_ce_cnt), .ue_cnt(b_ue_cnt),
    .log_valid(b_log_valid), .log_tag(b_log_tag), .log_syn(b_log_syn)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"},  out_data, 0);
    check({tag, " out_tag"},   out_tag, 0);
    check({tag, " out_ce"},    out_ce, 0);
    check({tag, " out_ue"},    out_ue, 0);
    check({tag, " out_syn"},   out_syn, 0);
    check({tag, " ce_cnt"},    ce_cnt, 0);
    check({tag, " ue_cnt"},    ue_cnt, 0);
    check({tag, " log_valid"}, log_valid, 0);
    check({tag, " log_tag"},   log_tag, 0);
    check({tag, " log_syn"},   log_syn, 0);
    check({tag, " in_ready"},  in_ready, 1);
  endtask

  // Offer one word, check 2-cycle latency and results, then let it drain.
  task automatic xfer(input string tag, input logic [38:0] code, input logic [3:0] t,
                      input logic [31:0] exp_data, input logic exp_ce, input logic exp_ue,
                      input logic [6:0] exp_syn);
    in_code  = code;
    in_tag   = t;
    in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " lat1 out_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_data"},  out_data, exp_data);
    check({tag, " out_tag"},   out_tag, t);
    check({tag, " out_ce"},    out_ce, exp_ce);
    check({tag, " out_ue"},    out_ue, exp_ue);
    check({tag, " out_syn"},   out_syn, exp_syn);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer("clean0", 39'h0, 4'h1, 32'h0, 0, 0, 7'h00);
    check("clean0 ce_cnt", ce_cnt, 0);
    xfer("ce_d0", 39'h4, 4'h2, 32'h0, 1, 0, 7'h43);
    check("ce_d0 ce_cnt", ce_cnt, 1);
    xfer("clean1", 39'h40_0000_0007, 4'h3, 32'h1, 0, 0, 7'h00);
    xfer("ce_d0b", 39'h40_0000_0003, 4'h4, 32'h1, 1, 0, 7'h43);
    check("ce_d0b ce_cnt", ce_cnt, 2);

    xfer("ue_dbl", 39'h14, 4'h5, 32'h3, 0, 1, 7'h06);
    check("ue_dbl ue_cnt", ue_cnt, 1);
    check("ue_dbl log_valid", log_valid, 1);
    check("ue_dbl log_tag", log_tag, 4'h5);
    check("ue_dbl log_syn", log_syn, 7'h06);
    xfer("ue_oor", 39'h00_8000_0012, 4'h6, 32'h2, 0, 1, 7'h67);
    check("ue_oor ue_cnt", ue_cnt, 2);
    check("ue_oor log_tag kept", log_tag, 4'h5);
    check("ue_oor log_syn kept", log_syn, 7'h06);

    xfer("ce_par", 39'h40_0000_0000, 4'h7, 32'h0, 1, 0, 7'h40);
    xfer("ce_chk31", 39'h00_8000_0000, 4'h8, 32'h0, 1, 0, 7'h60);
    check("chk31 ce_cnt", ce_cnt, 4);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 39'h0;
    in_tag    = 4'h9;
    check("bp A in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_code = 39'h40_0000_0007;
    in_tag  = 4'hA;
    check("bp B in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_code = 39'h4;
    in_tag  = 4'hB;
    check("bp full in_ready", in_ready, 0);
    check("bp stall tag", out_tag, 4'h9);
    @(posedge clk); #1;
    check("bp hold in_ready", in_ready, 0);
    check("bp hold out_valid", out_valid, 1);
    check("bp hold tag", out_tag, 4'h9);
    check("bp hold data", out_data, 32'h0);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp B tag", out_tag, 4'hA);
    check("bp B data", out_data, 32'h1);
    check("bp B ce", out_ce, 0);
    @(posedge clk); #1;
    check("bp C tag", out_tag, 4'hB);
    check("bp C ce", out_ce, 1);
    check("bp C syn", out_syn, 7'h43);
    @(posedge clk); #1;
    check("bp drained", out_valid, 0);
    check("bp ce_cnt", ce_cnt, 5);
    check("sat ce_cnt", b_ce_cnt, 2'd3);
    check("sat ue_cnt", b_ue_cnt, 2'd2);

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr ce_cnt", ce_cnt, 0);
    check("clr ue_cnt", ue_cnt, 0);
    check("clr log_valid", log_valid, 0);
    check("clr other inst", b_log_valid, 1);

    in_code  = 39'h4;
    in_tag   = 4'hC;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("coinc out_valid", out_valid, 1);
    clr_cnt2 = 1'b1;
    @(posedge clk); #1;
    clr_cnt2 = 1'b0;
    check("coinc clear wins", b_ce_cnt, 2'd0);
    check("coinc no clear", ce_cnt, 1);

    in_code  = 39'h14;
    in_tag   = 4'hD;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_code = 39'h4;
    in_tag  = 4'hE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    #10;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post rst out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
